gpio_wb_arbiter: RTL and testbench
==================================

GPIO_WB_ARBITER -- requirements
Module: gpio_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving slave-response watchdog limit in cycles (range 1..255).
REQ-002 SHALL have port wb_clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port wb_rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports m0_adr_i/m1_adr_i  in  1  master register address (0 data, 1 dir).
REQ-005 SHALL have ports m0_dat_i/m1_dat_i  in  8  master write data.
REQ-006 SHALL have ports m0_we_i/m1_we_i, m0_cyc_i/m1_cyc_i, m0_stb_i/m1_stb_i  in  1  Wishbone master controls.
REQ-007 SHALL have ports m0_dat_o/m1_dat_o  out  8  read data to master.
REQ-008 SHALL have ports m0_ack_o/m1_ack_o, m0_err_o/m1_err_o  out  1  termination to master.
REQ-009 SHALL have ports s_adr_o  out  1, s_dat_o  out  8, s_we_o/s_cyc_o/s_stb_o  out  1  to shared GPIO slave.
REQ-010 SHALL have ports s_dat_i  in  8, s_ack_i/s_err_i  in  1  from shared GPIO slave.

Function
REQ-011 SHALL implement FSM states IDLE, GNT0, GNT1, held in a register.
REQ-012 IDLE: SHALL move to GNT0 if only m0_cyc_i high, GNT1 if only m1_cyc_i high; if both high, grant the master not recorded in last-served register.
REQ-013 Grant SHALL be registered: one cycle from cyc assertion in IDLE to s_cyc_o assertion.
REQ-014 GNTx: SHALL hold grant while mx_cyc_i high (bus lock across bursts); on mx_cyc_i low SHALL return to IDLE next cycle and set last-served to x.
REQ-015 GNTx: s_adr_o/s_dat_o/s_we_o/s_cyc_o/s_stb_o SHALL combinationally follow master x; IDLE: s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=0, s_dat_o=0.
REQ-016 mx_ack_o/mx_err_o SHALL equal s_ack_i/s_err_i gated by grant to x; mx_dat_o SHALL equal s_dat_i when granted, else 0.
REQ-017 Non-granted master SHALL see ack=err=0 and is stalled indefinitely until granted; requests are never dropped.
REQ-018 A grant SHALL never switch while s_cyc_o high; IDLE lasts exactly one cycle between back-to-back grants.

Reset
REQ-019 wb_rst_n=0 at a clock edge SHALL force IDLE, last-served=m1 (so m0 wins first contention), watchdog count=0.
REQ-020 During and after reset, all outputs SHALL be 0 until next grant; reset mid-transfer SHALL abandon it without ack/err.

Configuration
REQ-021 Macro GPIO_WB_ARBITER_TIMEOUT_EN defined: 8-bit counter SHALL increment each cycle s_cyc_o&s_stb_o&!s_ack_i&!s_err_i, clear otherwise and in IDLE.
REQ-022 With macro, count reaching TIMEOUT SHALL drive granted mx_err_o=1 for one cycle, force s_cyc_o/s_stb_o=0 that cycle, clear counter, and move FSM to IDLE.
REQ-023 Without macro, no counter SHALL exist and err SHALL be pure passthrough of s_err_i.

Structure
REQ-024 Package gpio_wb_arbiter_pkg SHALL hold FSM state enum, NUM_MASTERS=2, counter width constant 8.
REQ-025 Watchdog SHALL be sub-module gpio_wb_arbiter_wdt, instantiated only under the macro.

Verification
REQ-026 m0 writes 0xA5 adr 0 alone -> s_cyc_o high cycle after m0_cyc_i, s_dat_o=0xA5, m0_ack_o on s_ack_i, m1_ack_o=0.
REQ-027 m0,m1 assert cyc same cycle after reset -> m0 granted; m0 drops cyc -> one IDLE cycle -> m1 granted.
REQ-028 Both continuously requesting 4 single transfers each -> grants alternate 0,1,0,1,..., none lost.
REQ-029 m1 reads adr 1, slave returns 0x3C -> m1_dat_o=0x3C with m1_ack_o, m0_dat_o=0.
REQ-030 Macro on, TIMEOUT=15, slave never acks -> granted mx_err_o pulses exactly 15 cycles after s_stb_o, FSM IDLE next; macro off -> stalls, no err.
REQ-031 wb_rst_n low mid-transfer in GNT1 -> next cycle IDLE, all outputs 0, no ack/err delivered.

Source files
------------

// File: rtl/gpio_wb_arbiter_pkg.sv
// Shared types and constants for the two-master GPIO Wishbone arbiter.
package gpio_wb_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned CNT_W       = 8;

  typedef logic [$clog2(NUM_MASTERS)-1:0] master_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gpio_wb_arbiter_wdt.sv
// Slave-response watchdog: counts stalled strobe cycles and flags TIMEOUT.
module gpio_wb_arbiter_wdt
  import gpio_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic clr,
  input  logic stall,
  output logic timeout
);

  logic [CNT_W-1:0] count;

  assign timeout = (count == CNT_W'(TIMEOUT));

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n || clr || timeout || !stall) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gpio_wb_arbiter.sv
// Two-master Wishbone arbiter in front of a shared GPIO slave, round-robin on contention.
// Define GPIO_WB_ARBITER_TIMEOUT_EN to add the slave-response watchdog.
module gpio_wb_arbiter
  import gpio_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       m0_adr_i,
  input  logic [7:0] m0_dat_i,
  input  logic       m0_we_i,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_adr_i,
  input  logic [7:0] m1_dat_i,
  input  logic       m1_we_i,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       s_adr_o,
  output logic [7:0] s_dat_o,
  output logic       s_we_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  input  logic       s_err_i
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("gpio_wb_arbiter: TIMEOUT must be in 1..255");
  end

  arb_state_e  state, state_nxt;
  master_idx_t last_served, last_nxt;
  logic        gnt0, gnt1;
  logic        cyc_raw, stb_raw;
  logic        timeout;

  // Grants are also gated by reset so every output is quiet while reset is held.
  assign gnt0 = wb_rst_n && (state == GNT0);
  assign gnt1 = wb_rst_n && (state == GNT1);

  always_comb begin
    s_adr_o = 1'b0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    cyc_raw = 1'b0;
    stb_raw = 1'b0;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      cyc_raw = m0_cyc_i;
      stb_raw = m0_stb_i;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      cyc_raw = m1_cyc_i;
      stb_raw = m1_stb_i;
    end
  end

`ifdef GPIO_WB_ARBITER_TIMEOUT_EN
  gpio_wb_arbiter_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .clr     (state == IDLE),
    .stall   (cyc_raw && stb_raw && !s_ack_i && !s_err_i),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // On a watchdog expiry the slave cycle is withdrawn and the master gets err instead.
  assign s_cyc_o  = cyc_raw && !timeout;
  assign s_stb_o  = stb_raw && !timeout;

  assign m0_ack_o = gnt0 && s_ack_i && !timeout;
  assign m1_ack_o = gnt1 && s_ack_i && !timeout;
  assign m0_err_o = gnt0 && (s_err_i || timeout);
  assign m1_err_o = gnt1 && (s_err_i || timeout);
  assign m0_dat_o = gnt0 ? s_dat_i : '0;
  assign m1_dat_o = gnt1 ? s_dat_i : '0;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_served;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = (last_served == master_idx_t'(1)) ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || timeout) begin
          state_nxt = IDLE;
          last_nxt  = master_idx_t'(0);
        end
      end
      GNT1: begin
        if (!m1_cyc_i || timeout) begin
          state_nxt = IDLE;
          last_nxt  = master_idx_t'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      last_served <= master_idx_t'(1);
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Directed self-checking bench for gpio_wb_arbiter (both watchdog builds).
module tb_gpio_wb_arbiter;

  logic       wb_clk;
  logic       wb_rst_n;
  logic       m0_adr_i, m1_adr_i;
  logic [7:0] m0_dat_i, m1_dat_i;
  logic       m0_we_i, m0_cyc_i, m0_stb_i;
  logic       m1_we_i, m1_cyc_i, m1_stb_i;
  logic [7:0] m0_dat_o, m1_dat_o;
  logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic       s_adr_o, s_we_o, s_cyc_o, s_stb_o;
  logic [7:0] s_dat_o;
  logic [7:0] s_dat_i;
  logic       s_ack_i, s_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_wb_arbiter #(
    .TIMEOUT(15)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i),
    .m0_we_i (m0_we_i),
    .m0_cyc_i(m0_cyc_i),
    .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i),
    .m1_we_i (m1_we_i),
    .m1_cyc_i(m1_cyc_i),
    .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic test_reset();
    wb_rst_n = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_dat_i = 8'hFF;
    s_ack_i = 1'b1; s_err_i = 1'b1; s_dat_i = 8'h77;
    step(); step();
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_s_cyc: got %b want 0", s_cyc_o); end
    n_checks++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_s_stb: got %b want 0", s_stb_o); end
    n_checks++; if (s_dat_o !== 8'h00) begin n_fail++; $display("FAIL rst_s_dat: got %h want 00", s_dat_o); end
    n_checks++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_m0_ack: got %b want 0", m0_ack_o); end
    n_checks++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_m0_err: got %b want 0", m0_err_o); end
    n_checks++; if (m0_dat_o !== 8'h00) begin n_fail++; $display("FAIL rst_m0_dat: got %h want 00", m0_dat_o); end
    n_checks++; if (m1_dat_o !== 8'h00) begin n_fail++; $display("FAIL rst_m1_dat: got %h want 00", m1_dat_o); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_dat_i = 8'h00;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = 8'h00;
    wb_rst_n = 1'b1;
    step();
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_cyc: got %b want 0", s_cyc_o); end
  endtask

  task automatic test_contention();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 1'b0; m0_dat_i = 8'h11;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 1'b1; m1_dat_i = 8'h22;
    #1;
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL cont_registered: got %b want 0", s_cyc_o); end
    step();
    n_checks++; if (s_dat_o !== 8'h11) begin n_fail++; $display("FAIL cont_first_m0: got %h want 11", s_dat_o); end
    n_checks++; if (s_adr_o !== 1'b0) begin n_fail++; $display("FAIL cont_adr_m0: got %b want 0", s_adr_o); end
    s_ack_i = 1'b1; #1;
    n_checks++; if (m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL cont_m0_ack: got %b want 1", m0_ack_o); end
    n_checks++; if (m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL cont_m1_noack: got %b want 0", m1_ack_o); end
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; #1;
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL cont_m0_drop: got %b want 0", s_cyc_o); end
    step();
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL cont_idle_gap: got %b want 0", s_cyc_o); end
    step();
    n_checks++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL cont_m1_cyc: got %b want 1", s_cyc_o); end
    n_checks++; if (s_adr_o !== 1'b1) begin n_fail++; $display("FAIL cont_m1_adr: got %b want 1", s_adr_o); end
    n_checks++; if (s_dat_o !== 8'h22) begin n_fail++; $display("FAIL cont_m1_dat: got %h want 22", s_dat_o); end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
  endtask

  task automatic test_write_m0();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 1'b0; m0_dat_i = 8'hA5;
    #1;
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wr_registered: got %b want 0", s_cyc_o); end
    step();
    n_checks++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL wr_s_cyc: got %b want 1", s_cyc_o); end
    n_checks++; if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL wr_s_stb: got %b want 1", s_stb_o); end
    n_checks++; if (s_we_o !== 1'b1) begin n_fail++; $display("FAIL wr_s_we: got %b want 1", s_we_o); end
    n_checks++; if (s_dat_o !== 8'hA5) begin n_fail++; $display("FAIL wr_s_dat: got %h want a5", s_dat_o); end
    n_checks++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: got %b want 0", m0_ack_o); end
    s_ack_i = 1'b1; #1;
    n_checks++; if (m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL wr_m0_ack: got %b want 1", m0_ack_o); end
    n_checks++; if (m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_m1_ack: got %b want 0", m1_ack_o); end
    s_ack_i = 1'b0; s_err_i = 1'b1; #1;
    n_checks++; if (m0_err_o !== 1'b1) begin n_fail++; $display("FAIL wr_m0_err: got %b want 1", m0_err_o); end
    n_checks++; if (m1_err_o !== 1'b0) begin n_fail++; $display("FAIL wr_m1_err: got %b want 0", m1_err_o); end
    s_err_i = 1'b0;
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
  endtask

  task automatic test_read_m1();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 1'b1;
    step();
    s_dat_i = 8'h3C; s_ack_i = 1'b1; #1;
    n_checks++; if (m1_dat_o !== 8'h3C) begin n_fail++; $display("FAIL rd_m1_dat: got %h want 3c", m1_dat_o); end
    n_checks++; if (m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL rd_m1_ack: got %b want 1", m1_ack_o); end
    n_checks++; if (m0_dat_o !== 8'h00) begin n_fail++; $display("FAIL rd_m0_dat: got %h want 00", m0_dat_o); end
    n_checks++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_m0_ack: got %b want 0", m0_ack_o); end
    n_checks++; if (s_adr_o !== 1'b1) begin n_fail++; $display("FAIL rd_s_adr: got %b want 1", s_adr_o); end
    n_checks++; if (s_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_s_we: got %b want 0", s_we_o); end
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    n_checks++; if (m1_dat_o !== 8'h00) begin n_fail++; $display("FAIL rd_idle_dat: got %h want 00", m1_dat_o); end
    s_dat_i = 8'h00;
  endtask

  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    int e;
    logic [7:0] expd;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 1'b0; m0_dat_i = 8'hA0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 1'b1; m1_dat_i = 8'hB0;
    #1;
    for (int i = 0; i < 8; i++) begin
      e    = i % 2;
      expd = (e == 0) ? 8'hA0 + 8'(n0) : 8'hB0 + 8'(n1);
      n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_cyc[%0d]: got %b want 0", i, s_cyc_o); end
      n_checks++; if (s_dat_o !== 8'h00) begin n_fail++; $display("FAIL b2b_idle_dat[%0d]: got %h want 00", i, s_dat_o); end
      step();
      n_checks++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt_cyc[%0d]: got %b want 1", i, s_cyc_o); end
      n_checks++; if (s_dat_o !== expd) begin n_fail++; $display("FAIL b2b_gnt_dat[%0d]: got %h want %h", i, s_dat_o, expd); end
      s_ack_i = 1'b1; #1;
      n_checks++; if (m0_ack_o !== (e == 0)) begin n_fail++; $display("FAIL b2b_m0_ack[%0d]: got %b want %b", i, m0_ack_o, e == 0); end
      n_checks++; if (m1_ack_o !== (e == 1)) begin n_fail++; $display("FAIL b2b_m1_ack[%0d]: got %b want %b", i, m1_ack_o, e == 1); end
      step();
      s_ack_i = 1'b0;
      if (e == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; n0++; end
      else        begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; n1++; end
      #1;
      n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drop[%0d]: got %b want 0", i, s_cyc_o); end
      step();
      if (e == 0 && n0 < 4) begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_dat_i = 8'hA0 + 8'(n0); end
      if (e == 1 && n1 < 4) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_dat_i = 8'hB0 + 8'(n1); end
      #1;
    end
  endtask

  task automatic test_timeout();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 1'b1;
    step();
`ifdef GPIO_WB_ARBITER_TIMEOUT_EN
    for (int j = 0; j < 15; j++) begin
      n_checks++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL wdt_early_err[%0d]: got %b want 0", j, m0_err_o); end
      n_checks++; if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL wdt_stb[%0d]: got %b want 1", j, s_stb_o); end
      step();
    end
    n_checks++; if (m0_err_o !== 1'b1) begin n_fail++; $display("FAIL wdt_err: got %b want 1", m0_err_o); end
    n_checks++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL wdt_stb_forced: got %b want 0", s_stb_o); end
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wdt_cyc_forced: got %b want 0", s_cyc_o); end
    n_checks++; if (m1_err_o !== 1'b0) begin n_fail++; $display("FAIL wdt_m1_err: got %b want 0", m1_err_o); end
    step();
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wdt_idle_cyc: got %b want 0", s_cyc_o); end
    n_checks++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL wdt_err_pulse: got %b want 0", m0_err_o); end
`else
    for (int j = 0; j < 30; j++) begin
      n_checks++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL stall_err[%0d]: got %b want 0", j, m0_err_o); end
      n_checks++; if (s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL stall_cyc[%0d]: got %b want 1", j, s_cyc_o); end
      step();
    end
`endif
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 1'b1; m1_dat_i = 8'h5A;
    step();
    n_checks++; if (s_dat_o !== 8'h5A) begin n_fail++; $display("FAIL rmid_gnt1: got %h want 5a", s_dat_o); end
    wb_rst_n = 1'b0; s_ack_i = 1'b1; s_err_i = 1'b1; #1;
    n_checks++; if (m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_during: got %b want 0", m1_ack_o); end
    n_checks++; if (m1_err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_err_during: got %b want 0", m1_err_o); end
    step();
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rmid_cyc: got %b want 0", s_cyc_o); end
    n_checks++; if (s_dat_o !== 8'h00) begin n_fail++; $display("FAIL rmid_dat: got %h want 00", s_dat_o); end
    n_checks++; if (m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ack: got %b want 0", m1_ack_o); end
    n_checks++; if (m1_err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", m1_err_o); end
    s_ack_i = 1'b0; s_err_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 1'b0; m0_dat_i = 8'h66;
    wb_rst_n = 1'b1; #1;
    n_checks++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got %b want 0", s_cyc_o); end
    step();
    n_checks++; if (s_dat_o !== 8'h66) begin n_fail++; $display("FAIL rmid_m0_first: got %h want 66", s_dat_o); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    wb_rst_n = 1'b0;
    m0_adr_i = 1'b0; m0_dat_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = 1'b0; m1_dat_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    test_reset();
    test_contention();
    test_write_m0();
    test_read_m1();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
